// File: rtl/intfdmx8.sv
// intfdmx8: serial-to-parallel frame demultiplexer.
// Recovers a MUX-slot parallel word from a time-division serial stream that
// is framed by isyn. Each slot lasts MAXTS synclk cycles and is sampled at
// offset SMPTS. The block also tracks frame alignment (olock), flags aborted
// frames (oerr) and drops lock if frame starts stop arriving.
//
// Handshake: ovld is a one-cycle, registered qualifier for odat. No ready
// path exists. odat changes only in the cycle where ovld is high and holds
// its value at all other times.
module intfdmx8 #(
    parameter int LINEBIT = 1,
    parameter int MUX     = 4,
    parameter int BITTS   = 3,
    parameter int MAXTS   = 6,
    parameter int SMPTS   = 3,
    parameter int TMOMAX  = 63,
    localparam int DATABIT = LINEBIT * MUX
) (
    input  logic               synclk,
    input  logic               rst,
    input  logic [LINEBIT-1:0] idat,
    input  logic               isyn,
    output logic [DATABIT-1:0] odat,
    output logic               ovld,
    output logic               oerr,
    output logic               olock
);

    localparam int TMOW = $clog2(TMOMAX + 1);
    // Slot index needs to reach MUX (8 max) without wrapping.
    localparam int PHW  = 4;

    typedef enum logic {HUNT = 1'b0, CAPT = 1'b1} state_t;

    state_t             state;
    logic               isyn_d;
    logic               pend;
    logic [BITTS-1:0]   cntts;
    logic [PHW-1:0]     cntph;
    logic [DATABIT-1:0] shadow;
    logic [TMOW-1:0]    tmo;
    logic [1:0]         good;

    logic               fs;
    logic               complete;
    logic               abort;
    logic               active;
    logic               smp;
    logic               last;
    logic               tmo_hit;
    logic [BITTS-1:0]   pos_ts;
    logic [PHW-1:0]     pos_ph;
    logic [BITTS-1:0]   nxt_ts;
    logic [PHW-1:0]     nxt_ph;
    logic [DATABIT-1:0] shadow_nxt;

    // Decode frame start, the slot position of this cycle and the capture events.
    // The counters hold the position of the cycle after the one that loaded them.
    // A frame start forces this cycle to position zero, so the t0 cycle
    // counts as offset 0. This lets SMPTS=0 sample slot 0 on t0 itself.
    always_comb begin
        fs       = isyn & ~isyn_d;
        complete = (state == CAPT) && pend;
        abort    = fs && (state == CAPT) && !pend;
        active   = fs || ((state == CAPT) && !pend);
        pos_ts   = fs ? '0 : cntts;
        pos_ph   = fs ? '0 : cntph;
        if (pos_ts == BITTS'(MAXTS - 1)) begin
            nxt_ts = '0;
            nxt_ph = pos_ph + PHW'(1);
        end else begin
            nxt_ts = pos_ts + BITTS'(1);
            nxt_ph = pos_ph;
        end
        smp     = active && (pos_ts == BITTS'(SMPTS)) && (pos_ph < PHW'(MUX));
        last    = smp && (pos_ph == PHW'(MUX - 1));
        tmo_hit = !fs && (tmo == TMOW'(TMOMAX - 1));
        shadow_nxt = fs ? '0 : shadow;
        for (int k = 0; k < MUX; k++) begin
            if (smp && (pos_ph == PHW'(k))) begin
                shadow_nxt[DATABIT-1-k*LINEBIT -: LINEBIT] = idat;
            end
        end
    end

    // Capture FSM, slot counters, output word, lock tracking and timeout.
    always_ff @(posedge synclk) begin
        if (rst) begin
            state  <= HUNT;
            isyn_d <= 1'b1;
            pend   <= 1'b0;
            cntts  <= '0;
            cntph  <= '0;
            shadow <= '0;
            tmo    <= '0;
            good   <= '0;
            odat   <= '0;
            ovld   <= 1'b0;
            oerr   <= 1'b0;
            olock  <= 1'b0;
        end else begin
            isyn_d <= isyn;
            ovld   <= 1'b0;
            oerr   <= 1'b0;
            shadow <= shadow_nxt;
            pend   <= last;
            if (active) begin
                cntts <= nxt_ts;
                cntph <= nxt_ph;
            end
            // A frame start always (re)starts capture; completion returns to HUNT.
            if (fs) begin
                state <= CAPT;
            end else if (complete) begin
                state <= HUNT;
            end
            if (complete) begin
                odat <= shadow;
                ovld <= 1'b1;
                if (good != 2'd3) begin
                    good <= good + 2'd1;
                end
                if (good != 2'd0) begin
                    olock <= 1'b1;
                end
            end
            if (abort) begin
                oerr  <= 1'b1;
                olock <= 1'b0;
                good  <= '0;
            end
            if (fs) begin
                tmo <= '0;
            end else if (tmo != TMOW'(TMOMAX)) begin
                tmo <= tmo + TMOW'(1);
            end
            // Silent loss of frame starts: drop lock without flagging an error.
            if (tmo_hit) begin
                olock <= 1'b0;
                good  <= '0;
                state <= HUNT;
                pend  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_intfdmx8.sv
// tb_intfdmx8: bench for intfdmx8 in its default build and in a LINEBIT=2, MUX=8 build.
// Expected values come from a frame-level reference model. The model records
// every idat value it drives and rebuilds each word from the sample instants
// t0 + k*MAXTS + SMPTS.
module tb_intfdmx8;

    localparam int L1 = 1;
    localparam int M1 = 4;
    localparam int D1 = L1 * M1;
    localparam int L2 = 2;
    localparam int M2 = 8;
    localparam int D2 = L2 * M2;
    localparam int MAXTS  = 6;
    localparam int SMPTS  = 3;
    localparam int TMOMAX = 63;
    localparam int LAT1 = (M1 - 1) * MAXTS + SMPTS + 1;
    localparam int LAT2 = (M2 - 1) * MAXTS + SMPTS + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          isyn;
    logic [L1-1:0] idat;
    logic [D1-1:0] odat;
    logic          ovld, oerr, olock;
    logic          isyn2;
    logic [L2-1:0] idat2;
    logic [D2-1:0] odat2;
    logic          ovld2, oerr2, olock2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ovld = 0;
    int base;

    logic [L1-1:0] hist1 [0:4095];
    logic [L2-1:0] hist2 [0:4095];

    // Reference model state for the default build.
    logic          m1_prev;
    int            m1_t0, m1_last_fs, m1_good;
    logic          m1_lock;
    logic [D1-1:0] m1_odat;
    // Reference model state for the wide build.
    logic          m2_prev;
    int            m2_t0;
    logic [D2-1:0] m2_odat;

    intfdmx8 dut (
        .synclk(clk), .rst(rst), .idat(idat), .isyn(isyn),
        .odat(odat), .ovld(ovld), .oerr(oerr), .olock(olock)
    );

    intfdmx8 #(.LINEBIT(L2), .MUX(M2)) dut2 (
        .synclk(clk), .rst(rst), .idat(idat2), .isyn(isyn2),
        .odat(odat2), .ovld(ovld2), .oerr(oerr2), .olock(olock2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model1(input logic r, input logic s, input int e);
        logic [D1-1:0] w;
        logic eo, ee;
        eo = 1'b0;
        ee = 1'b0;
        if (r) begin
            m1_prev = 1'b1; m1_t0 = -1; m1_last_fs = e;
            m1_good = 0; m1_lock = 1'b0; m1_odat = '0;
        end else begin
            if (m1_t0 >= 0 && e == m1_t0 + LAT1) begin
                w = '0;
                for (int k = 0; k < M1; k++) begin
                    w = w | (D1'(hist1[m1_t0 + k*MAXTS + SMPTS]) << ((M1 - 1 - k) * L1));
                end
                m1_odat = w;
                eo = 1'b1;
                m1_good++;
                if (m1_good >= 2) m1_lock = 1'b1;
                m1_t0 = -1;
            end
            if (s && !m1_prev) begin
                if (m1_t0 >= 0) begin
                    ee = 1'b1; m1_lock = 1'b0; m1_good = 0;
                end
                m1_t0 = e;
                m1_last_fs = e;
            end else if (e - m1_last_fs == TMOMAX) begin
                m1_lock = 1'b0; m1_good = 0; m1_t0 = -1;
            end
            m1_prev = s;
        end
        chk("ovld", 32'(ovld), 32'(eo));
        chk("oerr", 32'(oerr), 32'(ee));
        chk("olock", 32'(olock), 32'(m1_lock));
        chk("odat", 32'(odat), 32'(m1_odat));
    endtask

    task automatic model2(input logic r, input logic s, input int e);
        logic [D2-1:0] w;
        logic eo, ee;
        eo = 1'b0;
        ee = 1'b0;
        if (r) begin
            m2_prev = 1'b1; m2_t0 = -1; m2_odat = '0;
        end else begin
            if (m2_t0 >= 0 && e == m2_t0 + LAT2) begin
                w = '0;
                for (int k = 0; k < M2; k++) begin
                    w = w | (D2'(hist2[m2_t0 + k*MAXTS + SMPTS]) << ((M2 - 1 - k) * L2));
                end
                m2_odat = w;
                eo = 1'b1;
                m2_t0 = -1;
            end
            if (s && !m2_prev) begin
                if (m2_t0 >= 0) ee = 1'b1;
                m2_t0 = e;
            end
            m2_prev = s;
        end
        chk("ovld2", 32'(ovld2), 32'(eo));
        chk("oerr2", 32'(oerr2), 32'(ee));
        chk("odat2", 32'(odat2), 32'(m2_odat));
    endtask

    // One synclk cycle: drive at the falling edge, check just after the rising edge.
    task automatic tick(input logic r, input logic s, input logic [L1-1:0] d,
                        input logic s2, input logic [L2-1:0] d2);
        int e;
        @(negedge clk);
        rst = r; isyn = s; idat = d; isyn2 = s2; idat2 = d2;
        e = cyc;
        hist1[e] = d;
        hist2[e] = d2;
        @(posedge clk);
        #1;
        model1(r, s, e);
        model2(r, s2, e);
        if (ovld) n_ovld++;
        cyc++;
    endtask

    // Frame start followed by g-1 more cycles; isyn stays high for at most one slot.
    task automatic frame_gap(input int g);
        int h;
        h = (g - 1 < MAXTS) ? g - 1 : MAXTS;
        for (int i = 0; i < g; i++) begin
            tick(1'b0, i < h, L1'($urandom), 1'b0, L2'($urandom));
        end
    endtask

    // 32-cycle frame whose slots carry the bits of pat (slot 0 in the MSBs).
    task automatic frame_pat(input logic [D1-1:0] pat);
        logic [L1-1:0] d;
        for (int i = 0; i < 32; i++) begin
            if (i < M1 * MAXTS) d = pat[(M1 - 1 - i / MAXTS) * L1 +: L1];
            else d = L1'($urandom);
            tick(1'b0, i < MAXTS, d, 1'b0, L2'($urandom));
        end
    endtask

    initial begin
        logic [L2-1:0] pat2 [0:M2-1];
        logic [L2-1:0] d2;
        pat2 = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        rst = 1'b1; isyn = 1'b1; idat = '0; isyn2 = 1'b0; idat2 = '0;
        m1_prev = 1'b1; m1_t0 = -1; m1_last_fs = 0; m1_good = 0; m1_lock = 1'b0; m1_odat = '0;
        m2_prev = 1'b1; m2_t0 = -1; m2_odat = '0;

        // Reset with isyn high, then release with isyn still high: no capture.
        repeat (3) tick(1'b1, 1'b1, L1'($urandom), 1'b0, L2'($urandom));
        repeat (5) tick(1'b0, 1'b1, L1'($urandom), 1'b0, L2'($urandom));
        repeat (4) tick(1'b0, 1'b0, L1'($urandom), 1'b0, L2'($urandom));

        // Nominal frame 1011, then two more good frames 32 cycles apart.
        base = n_ovld;
        frame_pat(4'b1011);
        chk("nominal_odat", 32'(odat), 32'hB);
        chk("nominal_one_ovld", 32'(n_ovld - base), 32'd1);
        frame_gap(32);
        frame_gap(32);
        chk("lock_held", 32'(olock), 32'd1);

        // Early resync ten cycles into a frame, then a clean frame.
        frame_gap(10);
        frame_gap(32);

        // Frame start on the exact load cycle of the previous frame.
        frame_gap(LAT1);
        frame_gap(LAT1);
        frame_gap(32);

        // Random frame spacing: mixes aborts, completions and lock changes.
        repeat (25) frame_gap($urandom_range(4, 40));

        // Lock, then starve frame starts until the timeout drops lock.
        frame_gap(32);
        frame_gap(32);
        chk("pre_timeout_lock", 32'(olock), 32'd1);
        repeat (80) tick(1'b0, 1'b0, L1'($urandom), 1'b0, L2'($urandom));
        chk("timeout_unlock", 32'(olock), 32'd0);

        // Reset fifteen cycles into a frame: that frame never produces ovld.
        base = n_ovld;
        for (int i = 0; i < 30; i++) begin
            tick(i == 15, i < MAXTS, L1'($urandom), 1'b0, L2'($urandom));
        end
        chk("rst_no_ovld", 32'(n_ovld - base), 32'd0);

        // Wide build: slots 3,2,1,0,3,2,1,0 give 16'hE4E4.
        for (int i = 0; i < 52; i++) begin
            if (i < M2 * MAXTS) d2 = pat2[i / MAXTS];
            else d2 = L2'($urandom);
            tick(1'b0, 1'b0, L1'($urandom), i < MAXTS, d2);
        end
        chk("wide_odat", 32'(odat2), 32'hE4E4);
        // Wide build with fully random per-cycle data.
        for (int i = 0; i < 52; i++) begin
            tick(1'b0, 1'b0, L1'($urandom), i < MAXTS, L2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
